// File: rtl/score_pkg.sv
// Shared types and helpers for the two-player BCD scoreboard:
// match states, winner codes, 7-segment decode and BCD arithmetic.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WON   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int MAX_DIGITS = 3;

  // Segment order a,f,b,g,e,c,d from bit 6 down to bit 0.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1110111;
      4'd1:    return 7'b0010010;
      4'd2:    return 7'b1011101;
      4'd3:    return 7'b1011011;
      4'd4:    return 7'b0111010;
      4'd5:    return 7'b1101011;
      4'd6:    return 7'b1101111;
      4'd7:    return 7'b1010010;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b1110111;
    endcase
  endfunction

  function automatic int digit_pitch(input int seg_t, input int seg_l, input int gap);
    return seg_l + 2 * seg_t + gap;
  endfunction

  // Increments the low ndig BCD digits; holds at all-9s instead of wrapping.
  function automatic logic [4*MAX_DIGITS-1:0] bcd_inc(input logic [4*MAX_DIGITS-1:0] v,
                                                      input int ndig);
    logic [4*MAX_DIGITS-1:0] r;
    logic carry;
    logic sat;
    r     = v;
    carry = 1'b1;
    sat   = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < ndig && v[4*i +: 4] != 4'd9) sat = 1'b0;
    if (!sat)
      for (int i = 0; i < MAX_DIGITS; i++)
        if (i < ndig && carry) begin
          if (r[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
    return r;
  endfunction

  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int n);
    int x;
    logic [4*MAX_DIGITS-1:0] r;
    x = n;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_renderer.sv
// Combinational hit test of the current pixel against one 7-segment glyph
// anchored at (X0, Y0); all segment bounds are inclusive.
module seg7_renderer
  import score_pkg::*;
#(
  parameter int X0    = 0,
  parameter int Y0    = 0,
  parameter int SEG_T = 10,
  parameter int SEG_L = 50
) (
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic [3:0]         digit,
  input  logic               blank,
  output logic               hit
);

  localparam int T = SEG_T;
  localparam int L = SEG_L;

  function automatic logic in_box(input int px, input int py, input int x_lo, input int x_hi,
                                  input int y_lo, input int y_hi);
    return (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi);
  endfunction

  int h;
  int v;
  logic [6:0] region;

  always_comb begin
    h = int'(hpos);
    v = int'(vpos);
    region[6] = in_box(h, v, X0+T,     X0+T+L,   Y0,           Y0+T);
    region[5] = in_box(h, v, X0,       X0+T,     Y0+T,         Y0+T+L);
    region[4] = in_box(h, v, X0+T+L,   X0+2*T+L, Y0+T,         Y0+T+L);
    region[3] = in_box(h, v, X0+T,     X0+T+L,   Y0+T+L,       Y0+2*T+L);
    region[2] = in_box(h, v, X0,       X0+T,     Y0+2*T+L,     Y0+2*T+2*L);
    region[1] = in_box(h, v, X0+T+L,   X0+2*T+L, Y0+2*T+L,     Y0+2*T+2*L);
    region[0] = in_box(h, v, X0+T,     X0+T+L,   Y0+2*T+2*L,   Y0+3*T+2*L);
    hit = !blank && |(region & seg7(digit));
  end

endmodule

// File: rtl/score_display.sv
// Two-player BCD scoreboard: score counters, match FSM with blinking winner,
// and zero-latency 7-segment overlay for the frame compositor.
//
// state | meaning
// PLAY  | points accepted, watching for a score equal to WIN_SCORE
// WON   | match decided; winner digits blink, points ignored
// CLEAR | one cycle: zero scores/winner, restart blink, back to PLAY
module score_display
  import score_pkg::*;
#(
  parameter int          HRES         = 1280,
  parameter int          VRES         = 720,
  parameter logic [23:0] COLOR        = 24'hCC99FF,
  parameter logic [23:0] WIN_COLOR    = 24'hFFFF00,
  parameter int          NUM_DIGITS   = 2,
  parameter int          SEG_T        = 10,
  parameter int          SEG_L        = 50,
  parameter int          DIGIT_GAP    = 20,
  parameter int          P1_H         = 30,
  parameter int          P2_H         = 1100,
  parameter int          V_START      = 30,
  parameter int          WIN_SCORE    = 11,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    fsync,
  input  logic signed [11:0]      hpos,
  input  logic signed [11:0]      vpos,
  input  logic                    point_p1,
  input  logic                    point_p2,
  input  logic                    clear,
  output logic [7:0]              pixel [0:2],
  output logic                    active,
  output logic                    game_over,
  output logic [1:0]              winner,
  output logic [4*NUM_DIGITS-1:0] score_p1,
  output logic [4*NUM_DIGITS-1:0] score_p2
);

  localparam int             W       = 4 * NUM_DIGITS;
  localparam int             PITCH   = digit_pitch(SEG_T, SEG_L, DIGIT_GAP);
  localparam logic [W-1:0]   WIN_BCD = W'(to_bcd(WIN_SCORE));
  localparam int             FCW     = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  state_t         state, state_nx;
  logic [W-1:0]   shadow_p1, shadow_p2;
  logic [W-1:0]   inc_p1, inc_p2;
  logic           win_p1_now, win_p2_now;
  logic           blink_on;
  logic [FCW-1:0] frame_cnt;

  assign inc_p1     = W'(bcd_inc(12'(score_p1), NUM_DIGITS));
  assign inc_p2     = W'(bcd_inc(12'(score_p2), NUM_DIGITS));
  assign win_p1_now = (score_p1 == WIN_BCD);
  assign win_p2_now = (score_p2 == WIN_BCD);
  assign game_over  = (state == WON);

  always_comb begin
    state_nx = state;
    case (state)
      PLAY:    if (clear) state_nx = CLEAR;
               else if (win_p1_now || win_p2_now) state_nx = WON;
      WON:     if (clear) state_nx = CLEAR;
      CLEAR:   state_nx = PLAY;
      default: state_nx = PLAY;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state     <= PLAY;
      score_p1  <= '0;
      score_p2  <= '0;
      shadow_p1 <= '0;
      shadow_p2 <= '0;
      winner    <= WIN_NONE;
      blink_on  <= 1'b1;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      // Shadows only move at frame start so a frame never shows two scores.
      if (fsync) begin
        shadow_p1 <= score_p1;
        shadow_p2 <= score_p2;
      end
      case (state)
        PLAY: if (!clear) begin
          if (point_p1) score_p1 <= inc_p1;
          if (point_p2) score_p2 <= inc_p2;
          if (win_p1_now || win_p2_now) winner <= {win_p2_now, win_p1_now};
        end
        WON: if (fsync) begin
          if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        CLEAR: begin
          score_p1  <= '0;
          score_p2  <= '0;
          winner    <= WIN_NONE;
          blink_on  <= 1'b1;
          frame_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  logic [NUM_DIGITS-1:0] hit_p1, hit_p2;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int LSB = 4 * (NUM_DIGITS - 1 - k);
    logic blank_p1, blank_p2;
    // A digit is a leading zero when it and every more significant digit are 0.
    assign blank_p1 = (k != NUM_DIGITS - 1) && (shadow_p1[W-1:LSB] == '0);
    assign blank_p2 = (k != NUM_DIGITS - 1) && (shadow_p2[W-1:LSB] == '0);

    seg7_renderer #(.X0(P1_H + k * PITCH), .Y0(V_START), .SEG_T(SEG_T), .SEG_L(SEG_L)) u_p1 (
      .hpos(hpos), .vpos(vpos), .digit(shadow_p1[LSB +: 4]), .blank(blank_p1), .hit(hit_p1[k])
    );
    seg7_renderer #(.X0(P2_H + k * PITCH), .Y0(V_START), .SEG_T(SEG_T), .SEG_L(SEG_L)) u_p2 (
      .hpos(hpos), .vpos(vpos), .digit(shadow_p2[LSB +: 4]), .blank(blank_p2), .hit(hit_p2[k])
    );
  end

  logic        on_screen, won_p1, won_p2, vis_p1, vis_p2;
  logic [23:0] rgb;

  always_comb begin
    on_screen = (int'(hpos) < HRES) && (int'(vpos) < VRES);
    won_p1    = game_over && winner[0];
    won_p2    = game_over && winner[1];
    vis_p1    = on_screen && (|hit_p1) && !(won_p1 && !blink_on);
    vis_p2    = on_screen && (|hit_p2) && !(won_p2 && !blink_on);
    rgb       = '0;
    if (vis_p1)      rgb = won_p1 ? WIN_COLOR : COLOR;
    else if (vis_p2) rgb = won_p2 ? WIN_COLOR : COLOR;
    active   = vis_p1 | vis_p2;
    pixel[2] = rgb[23:16];
    pixel[1] = rgb[15:8];
    pixel[0] = rgb[7:0];
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench: the driver queues hand-computed expectations, the monitor
// drains the queue on each falling edge and compares against the DUT outputs.
module tb_score_display;

  logic              pixel_clk = 1'b0;
  logic              rst = 1'b1;
  logic              fsync = 1'b0;
  logic signed [11:0] hpos = '0;
  logic signed [11:0] vpos = '0;
  logic              point_p1 = 1'b0;
  logic              point_p2 = 1'b0;
  logic              clear = 1'b0;

  logic [7:0] pixel [0:2];
  logic       active, game_over;
  logic [1:0] winner;
  logic [7:0] score_p1, score_p2;

  logic [7:0] pixel99 [0:2];
  logic       active99, game_over99;
  logic [1:0] winner99;
  logic [7:0] score99_p1, score99_p2;

  localparam logic [23:0] COLOR     = 24'hCC99FF;
  localparam logic [23:0] WIN_COLOR = 24'hFFFF00;

  always #5 pixel_clk = ~pixel_clk;

  score_display dut (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .point_p1(point_p1), .point_p2(point_p2), .clear(clear),
    .pixel(pixel), .active(active), .game_over(game_over), .winner(winner),
    .score_p1(score_p1), .score_p2(score_p2)
  );

  score_display #(.NUM_DIGITS(2), .WIN_SCORE(99)) dut99 (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .point_p1(point_p1), .point_p2(point_p2), .clear(clear),
    .pixel(pixel99), .active(active99), .game_over(game_over99), .winner(winner99),
    .score_p1(score99_p1), .score_p2(score99_p2)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [23:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  always @(negedge pixel_clk) begin
    exp_t        e;
    logic [23:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       act = {16'h0, score_p1};
        1:       act = {16'h0, score_p2};
        2:       act = {23'h0, game_over};
        3:       act = {22'h0, winner};
        4:       act = {23'h0, active};
        5:       act = {pixel[2], pixel[1], pixel[0]};
        6:       act = {16'h0, score99_p1};
        default: act = {23'h0, game_over99};
      endcase
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  task automatic pulse(input logic a, input logic b, input logic c);
    point_p1 = a;
    point_p2 = b;
    clear    = c;
    tick(1);
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic pulses(input logic a, input logic b, input int n);
    repeat (n) pulse(a, b, 1'b0);
  endtask

  task automatic do_fsync();
    fsync = 1'b1;
    tick(1);
    fsync = 1'b0;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [23:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Let the monitor drain at the falling edge, then realign just after a rising edge.
  task automatic flush();
    @(negedge pixel_clk);
    #1;
    tick(1);
  endtask

  task automatic expect_px(input string name, input int h, input int v, input int sel,
                           input logic [23:0] exp);
    hpos = 12'(h);
    vpos = 12'(v);
    expect_sig(name, sel, exp);
    flush();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    rst = 1'b0;
    expect_sig("rst_score_p1", 0, 24'h0);
    expect_sig("rst_score_p2", 1, 24'h0);
    expect_sig("rst_game_over", 2, 24'h0);
    expect_sig("rst_winner", 3, 24'h0);
    flush();
    expect_px("rst_p1_tens_blank", 35, 60, 4, 24'h0);
    expect_px("rst_p1_units_zero_f", 125, 60, 4, 24'h1);

    // Three points; the display keeps showing "0" until the next frame start.
    pulses(1'b1, 1'b0, 3);
    expect_sig("p1_three", 0, 24'h03);
    flush();
    expect_px("pre_fsync_units_f", 125, 60, 4, 24'h1);
    expect_px("pre_fsync_units_g", 155, 95, 4, 24'h0);
    do_fsync();
    expect_px("post_fsync_units_f", 125, 60, 4, 24'h0);
    expect_px("post_fsync_units_g", 155, 95, 5, COLOR);
    expect_px("post_fsync_tens_blank", 35, 60, 4, 24'h0);

    // Carry from 09 to 10.
    pulses(1'b1, 1'b0, 6);
    expect_sig("p1_nine", 0, 24'h09);
    flush();
    pulse(1'b1, 1'b0, 1'b0);
    expect_sig("p1_carry", 0, 24'h10);
    flush();
    do_fsync();
    expect_px("p1_tens1_b", 95, 60, 5, COLOR);
    expect_px("p1_tens1_c", 95, 120, 4, 24'h1);
    expect_px("p1_units0_f", 125, 60, 4, 24'h1);

    // Simultaneous points take both to 11: a draw one cycle later.
    pulses(1'b0, 1'b1, 10);
    expect_sig("p2_ten", 1, 24'h10);
    flush();
    pulse(1'b1, 1'b1, 1'b0);
    expect_sig("both_p1_11", 0, 24'h11);
    expect_sig("both_p2_11", 1, 24'h11);
    expect_sig("draw_not_yet_over", 2, 24'h0);
    flush();
    expect_sig("draw_game_over", 2, 24'h1);
    expect_sig("draw_winner", 3, 24'h3);
    flush();
    do_fsync();
    expect_px("draw_p1_blink_on", 95, 60, 5, WIN_COLOR);
    repeat (29) do_fsync();
    expect_px("draw_p1_blink_off", 95, 60, 4, 24'h0);

    pulse(1'b0, 1'b0, 1'b1);
    expect_sig("clear_state_left_won", 2, 24'h0);
    flush();
    expect_sig("clear_winner", 3, 24'h0);
    expect_sig("clear_p1", 0, 24'h0);
    expect_sig("clear_p2", 1, 24'h0);
    flush();

    // Player 2 wins; watch two blink half-periods.
    pulses(1'b1, 1'b0, 2);
    pulses(1'b0, 1'b1, 11);
    expect_sig("p2_eleven", 1, 24'h11);
    expect_sig("p2_not_yet_over", 2, 24'h0);
    flush();
    expect_sig("p2_game_over", 2, 24'h1);
    expect_sig("p2_winner", 3, 24'h2);
    flush();
    for (int i = 1; i <= 60; i++) begin
      do_fsync();
      expect_px("p2_blink", 1165, 60, 5, ((i / 30) % 2 == 0) ? WIN_COLOR : 24'h0);
      if (i == 30) expect_px("p2_blink_off_active", 1165, 60, 4, 24'h0);
      if (i == 1 || i == 45) expect_px("p1_loser_color", 155, 35, 5, COLOR);
    end

    // clear with a same-cycle point in WON: point ignored, fresh match.
    pulse(1'b0, 1'b1, 1'b1);
    expect_sig("won_clear_over", 2, 24'h0);
    expect_sig("won_point_ignored", 1, 24'h11);
    flush();
    expect_sig("restart_p1", 0, 24'h0);
    expect_sig("restart_p2", 1, 24'h0);
    expect_sig("restart_winner", 3, 24'h0);
    flush();
    pulse(1'b1, 1'b0, 1'b1);
    expect_sig("play_clear_priority", 0, 24'h0);
    flush();

    // WIN_SCORE=99 instance: reset mid-sequence, then run to saturation.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (i == 49) rst = 1'b1;
      pulse(1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      if (i == 48) begin
        expect_sig("w99_before_rst", 6, 24'h49);
        flush();
      end
      if (i == 49) begin
        expect_sig("w99_rst_zero", 6, 24'h00);
        flush();
      end
    end
    expect_sig("w99_resumed", 6, 24'h70);
    flush();
    pulses(1'b1, 1'b0, 40);
    expect_sig("w99_saturated", 6, 24'h99);
    expect_sig("w99_game_over", 7, 24'h1);
    flush();

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
